pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register for the MIPS core; replaces the hard-wired ID->EX latch.
//  Adds valid/ready flow control, synchronous flush, NOP-bubble insertion and an optional skid buffer.
//  Instantiated between every stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB); the payload is the packed stage bundle.
// PARAMETERS
//  DATA_W       81          payload width; default ID->EX bundle = aluop8+alusel3+reg1 32+reg2 32+wd5+wreg1
//  NOP_PAYLOAD  {DATA_W{0}} payload driven on m_data whenever m_valid=0 (NOP op, NOP sel, zero regs, no write)
// PORTS
//  clk       in   1       clock; all state updates on posedge
//  rst       in   1       reset, synchronous, active-low
//  flush     in   1       discard all held and incoming entries this cycle
//  s_valid   in   1       upstream payload valid
//  s_ready   out  1       stage can accept; transfer when s_valid&&s_ready
//  s_data    in   DATA_W  upstream payload
//  m_valid   out  1       downstream payload valid
//  m_ready   in   1       downstream accepts; transfer when m_valid&&m_ready
//  m_data    out  DATA_W  downstream payload; NOP_PAYLOAD when m_valid=0
//  occupancy out  2       entries held (0..2; max 1 without skid)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): m_valid=0, m_data=NOP_PAYLOAD, occupancy=0, skid emptied; s_ready=1 from first cycle after.
//  - While rst=0, inputs are ignored and no transfer occurs on either side.
//  - Latency: 1 cycle s-side transfer -> m_valid. Throughput: 1 beat/cycle when m_ready=1.
//  - m_data is stable and m_valid held while m_valid&&!m_ready (no drop, no reorder).
//  - Flush (priority over everything but reset): next cycle m_valid=0, m_data=NOP_PAYLOAD, occupancy=0;
//    any s-side beat handshaked in the flush cycle is dropped; m-side handshake in that cycle still counts.
//  - Bubble: when m_valid=0, m_data is forced to NOP_PAYLOAD (never stale data).
//  - Skid FSM (PIPE_SKID_EN): states EMPTY(occ 0), BUSY(occ 1), FULL(occ 2).
//     EMPTY: s-xfer -> BUSY.
//     BUSY : s-xfer & m-xfer -> BUSY (main <= s_data); s-xfer only -> FULL (skid <= s_data);
//            m-xfer only -> EMPTY.
//     FULL : m-xfer -> BUSY (main <= skid); s_ready=0 so no s-xfer.
//     flush from any state -> EMPTY.
//     s_ready is a register: 1 in EMPTY/BUSY, 0 in FULL (no comb path m_ready->s_ready).
//  - Single-register mode: s_ready = !m_valid || m_ready (combinational); simultaneous in/out replaces
//    the entry in place.
// CONFIGURATION
//  PIPE_SKID_EN defined  : 2-entry skid buffer, registered s_ready, FSM above, occupancy 0..2.
//  PIPE_SKID_EN undefined: single register, combinational s_ready, occupancy 0..1, no skid storage.
//  Port list identical in both builds.
// STRUCTURE
//  Shared package mips_pipe_pkg: ALUOP_W/ALUSEL_W/REG_W/REGADDR_W, EXE_NOP_OP, EXE_RES_NOP, ZEROWORD,
//  NOPREGADDR, ID_EX_W and the ID_EX_NOP packed constant, skid-state encoding (EMPTY/BUSY/FULL).
//  Sub-module pipe_skid_buf (skid slot + FSM + registered ready), instantiated only under PIPE_SKID_EN;
//  top level owns main register, bubble mux, flush and occupancy.
// TESTING
//  1 reset: rst=0 for 2 cycles with s_valid=1, s_data=81'h1_2345 -> m_valid=0, m_data=0, occupancy=0.
//  2 streaming: m_ready=1, beats A,B,C on consecutive cycles -> m_data A,B,C with 1-cycle latency, no gaps.
//  3 backpressure: m_ready=0 after A accepted, drive B,C -> skid build: s_ready=0 after B, occupancy=2,
//    m_data holds A; release -> A,B in order, C accepted next. Non-skid: s_ready=0 immediately, occ=1.
//  4 flush: occupancy=2, flush=1 with s_valid=1, s_data=D -> next cycle m_valid=0, m_data=NOP, D never emerges.
//  5 simultaneous: BUSY, s-xfer E and m-xfer in same cycle -> occupancy stays 1, m_data=E next cycle.
//  6 reset mid-operation: FULL state, rst=0 one cycle -> EMPTY, s_ready=1, held beats lost.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: ID->EX bundle layout, its NOP encoding and the
// skid-buffer state encoding used by pipe_stage_reg / pipe_skid_buf.
package mips_pipe_pkg;

    localparam int ALUOP_W   = 8;
    localparam int ALUSEL_W  = 3;
    localparam int REG_W     = 32;
    localparam int REGADDR_W = 5;

    localparam logic [ALUOP_W-1:0]   EXE_NOP_OP  = '0;
    localparam logic [ALUSEL_W-1:0]  EXE_RES_NOP = '0;
    localparam logic [REG_W-1:0]     ZEROWORD    = '0;
    localparam logic [REGADDR_W-1:0] NOPREGADDR  = '0;

    localparam int ID_EX_W = ALUOP_W + ALUSEL_W + 2 * REG_W + REGADDR_W + 1;

    typedef struct packed {
        logic [ALUOP_W-1:0]   aluop;
        logic [ALUSEL_W-1:0]  alusel;
        logic [REG_W-1:0]     reg1;
        logic [REG_W-1:0]     reg2;
        logic [REGADDR_W-1:0] wd;
        logic                 wreg;
    } id_ex_t;

    localparam id_ex_t ID_EX_NOP = '{
        aluop:  EXE_NOP_OP,
        alusel: EXE_RES_NOP,
        reg1:   ZEROWORD,
        reg2:   ZEROWORD,
        wd:     NOPREGADDR,
        wreg:   1'b0
    };

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] skid_occ(input skid_state_e st);
        return st;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid slot, EMPTY/BUSY/FULL state machine and registered upstream ready.
// The main register lives in the top; this block tells it when and from where to load.
module pipe_skid_buf
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              m_ready_i,
    output logic              m_valid_o,
    output logic              ld_main_s_o,
    output logic              ld_main_skid_o,
    output logic [DATA_W-1:0] skid_data_o,
    output logic [1:0]        occupancy_o
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              s_ready_q, s_ready_d;
    logic              s_xfer, m_xfer;

    assign s_xfer = s_valid_i && s_ready_q;
    assign m_xfer = (state_q != SKID_EMPTY) && m_ready_i;

    always_comb begin
        state_d        = state_q;
        skid_d         = skid_q;
        ld_main_s_o    = 1'b0;
        ld_main_skid_o = 1'b0;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (s_xfer) begin
                        state_d     = SKID_BUSY;
                        ld_main_s_o = 1'b1;
                    end
                end
                SKID_BUSY: begin
                    if (s_xfer && m_xfer) begin
                        ld_main_s_o = 1'b1;
                    end else if (s_xfer) begin
                        state_d = SKID_FULL;
                        skid_d  = s_data_i;
                    end else if (m_xfer) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (m_xfer) begin
                        state_d        = SKID_BUSY;
                        ld_main_skid_o = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
        // Ready is computed from the next state so it can be registered without a bubble.
        s_ready_d = (state_d != SKID_FULL);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= SKID_EMPTY;
            skid_q    <= '0;
            s_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready_o   = s_ready_q;
    assign m_valid_o   = (state_q != SKID_EMPTY);
    assign skid_data_o = skid_q;
    assign occupancy_o = skid_occ(state_q);

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and NOP bubbles between MIPS stages.
// Define PIPE_SKID_EN for the 2-entry skid buffer with registered s_ready; otherwise single register.
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int                DATA_W      = ID_EX_W,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = DATA_W'(ID_EX_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] main_q, main_d;
    logic              m_valid_int;

`ifdef PIPE_SKID_EN
    logic              ld_main_s, ld_main_skid;
    logic [DATA_W-1:0] skid_data;

    pipe_skid_buf #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .s_data_i      (s_data),
        .m_ready_i     (m_ready),
        .m_valid_o     (m_valid_int),
        .ld_main_s_o   (ld_main_s),
        .ld_main_skid_o(ld_main_skid),
        .skid_data_o   (skid_data),
        .occupancy_o   (occupancy)
    );

    always_comb begin
        main_d = main_q;
        if (ld_main_skid) begin
            main_d = skid_data;
        end else if (ld_main_s) begin
            main_d = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q <= NOP_PAYLOAD;
        end else begin
            main_q <= main_d;
        end
    end
`else
    logic valid_q, valid_d;
    logic s_xfer, m_xfer;

    // A consumed entry frees the slot in the same cycle, so a full stage still streams.
    assign s_ready = !valid_q || m_ready;
    assign s_xfer  = s_valid && s_ready;
    assign m_xfer  = valid_q && m_ready;

    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
            main_d  = NOP_PAYLOAD;
        end else if (s_xfer) begin
            valid_d = 1'b1;
            main_d  = s_data;
        end else if (m_xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            main_q  <= NOP_PAYLOAD;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end

    assign m_valid_int = valid_q;
    assign occupancy   = {1'b0, valid_q};
`endif

    assign m_valid = m_valid_int;
    assign m_data  = m_valid_int ? main_q : NOP_PAYLOAD;

endmodule
